// File: rtl/div_unit.sv
// Iterative 32-bit radix-2 restoring divider (DIV/DIVU/REM/REMU) with a CDB result port.
// Optional macro DIV_UNIT_EARLY_OUT_EN: trivial cases (x/0, overflow, |a|<|b|) finish at the accept edge.
package riscv_pkg;
    localparam int TAG_WIDTH = 6;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_SLT, ALU_SLTU, ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } aluop_t;
endpackage

module div_unit
    import riscv_pkg::*;
#(
    parameter int TAG_WIDTH = riscv_pkg::TAG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    input  aluop_t               in_alu_ctrl,
    input  logic [31:0]          in_operand_a,
    input  logic [31:0]          in_operand_b,
    input  logic [TAG_WIDTH-1:0] in_dest_tag,
    output logic                 fu_free,
    output logic                 cdb_req,
    input  logic                 cdb_grant,
    output logic [TAG_WIDTH-1:0] cdb_tag,
    output logic [31:0]          cdb_data
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state;
    logic [4:0]           cnt;
    logic [63:0]          rq;
    logic [31:0]          dvsr;
    logic                 is_rem_q, q_neg_q, r_neg_q;
    logic [TAG_WIDTH-1:0] tag_q;

    assign fu_free = (state == IDLE) && !in_valid;

    logic        in_signed, in_rem, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    assign in_signed = (in_alu_ctrl == ALU_DIV) || (in_alu_ctrl == ALU_REM);
    assign in_rem    = (in_alu_ctrl == ALU_REM) || (in_alu_ctrl == ALU_REMU);
    assign a_neg     = in_signed && in_operand_a[31];
    assign b_neg     = in_signed && in_operand_b[31];
    assign a_mag     = a_neg ? -in_operand_a : in_operand_a;
    assign b_mag     = b_neg ? -in_operand_b : in_operand_b;

    // Shifted remainder needs 33 bits: an unsigned divisor can reach 2^32-1.
    logic [32:0] rem_sh;
    logic [33:0] diff;
    logic [63:0] rq_nxt;
    logic [31:0] q_fin, r_fin, res;
    assign rem_sh = rq[63:31];
    assign diff   = {1'b0, rem_sh} - {2'b00, dvsr};
    assign rq_nxt = diff[33] ? {rem_sh[31:0], rq[30:0], 1'b0}
                             : {diff[31:0],   rq[30:0], 1'b1};
    assign q_fin  = q_neg_q ? -rq_nxt[31:0]  : rq_nxt[31:0];
    assign r_fin  = r_neg_q ? -rq_nxt[63:32] : rq_nxt[63:32];
    assign res    = is_rem_q ? r_fin : q_fin;

`ifdef DIV_UNIT_EARLY_OUT_EN
    logic        eo_zero, eo_ovf, eo_hit;
    logic [31:0] eo_res;
    assign eo_zero = (in_operand_b == 32'd0);
    assign eo_ovf  = in_signed && (in_operand_a == 32'h8000_0000) && (in_operand_b == 32'hFFFF_FFFF);
    assign eo_hit  = eo_zero || eo_ovf || (a_mag < b_mag);
    always_comb begin
        eo_res = in_rem ? in_operand_a : 32'd0;
        if (eo_zero)
            eo_res = in_rem ? in_operand_a : 32'hFFFF_FFFF;
        else if (eo_ovf)
            eo_res = in_rem ? 32'd0 : 32'h8000_0000;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rq       <= '0;
            dvsr     <= '0;
            is_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            tag_q    <= '0;
            cdb_req  <= 1'b0;
            cdb_tag  <= '0;
            cdb_data <= '0;
        end else if (flush) begin
            state   <= IDLE;
            cnt     <= '0;
            cdb_req <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    tag_q    <= in_dest_tag;
                    is_rem_q <= in_rem;
                    // A zero divisor keeps the all-ones quotient unsigned-looking.
                    q_neg_q  <= in_signed && (in_operand_a[31] ^ in_operand_b[31])
                                && (in_operand_b != 32'd0);
                    r_neg_q  <= a_neg;
                    rq       <= {32'd0, a_mag};
                    dvsr     <= b_mag;
                    cnt      <= '0;
`ifdef DIV_UNIT_EARLY_OUT_EN
                    if (eo_hit) begin
                        state    <= DONE;
                        cdb_req  <= 1'b1;
                        cdb_tag  <= in_dest_tag;
                        cdb_data <= eo_res;
                    end else
`endif
                    state <= BUSY;
                end
                BUSY: begin
                    rq  <= rq_nxt;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state    <= DONE;
                        cdb_req  <= 1'b1;
                        cdb_tag  <= tag_q;
                        cdb_data <= res;
                    end
                end
                DONE: if (cdb_grant) begin
                    state   <= IDLE;
                    cdb_req <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_issue_when_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_valid && state != IDLE));

endmodule
